// File: rtl/alsu_result_fifo.sv
// Result capture FIFO behind the ALSU output register, with optional running statistics.
// Define ALSU_RESULT_STATS_EN to build the acc/invalid_cnt statistics logic.
module alsu_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OUT_W = 6,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    input  logic [OUT_W-1:0]           i_in_data,
    input  logic                       i_in_invalid,
    input  logic                       i_rd_en,
    input  logic                       i_clr,
    output logic                       o_rd_valid,
    output logic [OUT_W-1:0]           o_rd_data,
    output logic                       o_rd_invalid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic [ACC_W-1:0]           o_acc,
    output logic [CNT_W-1:0]           o_invalid_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [OUT_W:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_rd_valid;
    logic [OUT_W-1:0] r_rd_data;
    logic             r_rd_invalid;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_push  = i_in_valid && (!w_full || i_rd_en);
    assign w_pop   = i_rd_en && !w_empty;
    assign w_drop  = i_in_valid && w_full && !i_rd_en;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_invalid, i_in_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_invalid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_rd_data    <= r_mem[r_rd_ptr][OUT_W-1:0];
                r_rd_invalid <= r_mem[r_rd_ptr][OUT_W];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (i_clr) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef ALSU_RESULT_STATS_EN
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_invalid_cnt;
    logic [ACC_W-1:0] w_data_ext;

    assign w_data_ext = ACC_W'($signed(i_in_data));

    // Dropped writes still count toward the statistics.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc         <= '0;
            r_invalid_cnt <= '0;
        end else if (i_clr) begin
            r_acc         <= '0;
            r_invalid_cnt <= '0;
        end else if (i_in_valid) begin
            if (i_in_invalid) begin
                if (r_invalid_cnt != {CNT_W{1'b1}}) begin
                    r_invalid_cnt <= r_invalid_cnt + 1'b1;
                end
            end else begin
                r_acc <= r_acc + w_data_ext;
            end
        end
    end

    assign o_acc         = r_acc;
    assign o_invalid_cnt = r_invalid_cnt;
`else
    assign o_acc         = '0;
    assign o_invalid_cnt = '0;
`endif

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_rd_invalid = r_rd_invalid;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_alsu_result_fifo.sv
// Directed bench for alsu_result_fifo: scoreboard of written entries checked against pops,
// plus a cycle model of occupancy, overflow and statistics.
module tb_alsu_result_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned OUT_W = 6;
    localparam int unsigned ACC_W = 12;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [OUT_W-1:0] in_data;
    logic             in_invalid;
    logic             rd_en;
    logic             clr;
    logic             rd_valid;
    logic [OUT_W-1:0] rd_data;
    logic             rd_invalid;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] invalid_cnt;

    alsu_result_fifo #(
        .DEPTH(DEPTH),
        .OUT_W(OUT_W),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .i_in_invalid (in_invalid),
        .i_rd_en      (rd_en),
        .i_clr        (clr),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_rd_invalid (rd_invalid),
        .o_full       (full),
        .o_empty      (empty),
        .o_count      (count),
        .o_overflow   (overflow),
        .o_acc        (acc),
        .o_invalid_cnt(invalid_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [OUT_W:0]   sb[$];
    int               m_count;
    bit               m_ovf;
    logic [OUT_W-1:0] m_last;
    logic [ACC_W-1:0] m_acc;
    logic [CNT_W-1:0] m_inv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_last  = '0;
        m_acc   = '0;
        m_inv   = '0;
    endtask

    function automatic logic [ACC_W-1:0] exp_acc();
`ifdef ALSU_RESULT_STATS_EN
        return m_acc;
`else
        return '0;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] exp_inv();
`ifdef ALSU_RESULT_STATS_EN
        return m_inv;
`else
        return '0;
`endif
    endfunction

    // One clock: update the model from the driven inputs, then check outputs #1 after the edge.
    task automatic tick();
        bit             exp_pop;
        bit             exp_push;
        logic [OUT_W:0] head;
        exp_pop  = rd_en && (m_count > 0);
        exp_push = in_valid && ((m_count < DEPTH) || rd_en);
        if (exp_push) sb.push_back({in_invalid, in_data});
        if (clr) m_ovf = 1'b0;
        else if (in_valid && (m_count == DEPTH) && !rd_en) m_ovf = 1'b1;
        m_count = m_count + int'(exp_push) - int'(exp_pop);
        if (clr) begin
            m_acc = '0;
            m_inv = '0;
        end else if (in_valid) begin
            if (in_invalid) begin
                if (m_inv != 8'hFF) m_inv = m_inv + 1'b1;
            end else begin
                m_acc = m_acc + {{(ACC_W-OUT_W){in_data[OUT_W-1]}}, in_data};
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(exp_pop));
        if (exp_pop) begin
            head   = sb.pop_front();
            m_last = head[OUT_W-1:0];
            chk("rd_data", 32'(rd_data), 32'(head[OUT_W-1:0]));
            chk("rd_invalid", 32'(rd_invalid), 32'(head[OUT_W]));
        end else begin
            chk("rd_data_hold", 32'(rd_data), 32'(m_last));
        end
        chk("count", 32'(count), 32'(m_count));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("full", 32'(full), 32'(m_count == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("acc", 32'(acc), 32'(exp_acc()));
        chk("invalid_cnt", 32'(invalid_cnt), 32'(exp_inv()));
    endtask

    task automatic drive(input bit v, input logic [OUT_W-1:0] d, input bit inv, input bit rd,
                         input bit c);
        in_valid   = v;
        in_data    = d;
        in_invalid = inv;
        rd_en      = rd;
        clr        = c;
        tick();
        in_valid   = 1'b0;
        in_invalid = 1'b0;
        rd_en      = 1'b0;
        clr        = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_invalid = 1'b0;
        rd_en      = 1'b0;
        clr        = 1'b0;
        model_reset();

        // Reset state before any clock edge
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mid-stream asynchronous reset with 3 entries stored
        drive(1'b1, 6'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd11, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 6'd12, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Fill to 8, drop the 9th, drain in order
        for (int i = 1; i <= 8; i++) drive(1'b1, 6'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_last", 32'(rd_data), 32'd8);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_overflow", 32'(overflow), 32'd0);

        // Simultaneous read and write while full
        for (int i = 1; i <= 8; i++) drive(1'b1, 6'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd20, 1'b0, 1'b1, 1'b0);
        chk("sim_rd_data", 32'(rd_data), 32'd1);
        chk("sim_count", 32'(count), 32'd8);
        chk("sim_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("sim_last", 32'(rd_data), 32'd20);

        // Reads while empty: no pulse, data held
        for (int i = 0; i < 3; i++) drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("empty_rd_hold", 32'(rd_data), 32'd20);

        // Write into an empty FIFO with rd_en: stored, no bypass
        drive(1'b1, 6'd7, 1'b0, 1'b1, 1'b0);
        chk("nobypass_count", 32'(count), 32'd1);
        drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Statistics: -32, 31, -1, plus invalid 5
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 6'h20, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 6'h1F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 6'h3F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 6'd5, 1'b1, 1'b1, 1'b0);
`ifdef ALSU_RESULT_STATS_EN
        chk("acc_mix", 32'(acc), 32'hFFE);
        chk("inv_mix", 32'(invalid_cnt), 32'd1);
`else
        chk("acc_off", 32'(acc), 32'd0);
        chk("inv_off", 32'(invalid_cnt), 32'd0);
`endif
        for (int i = 0; i < 100; i++) drive(1'b1, 6'd31, 1'b0, 1'b1, 1'b0);
`ifdef ALSU_RESULT_STATS_EN
        chk("acc_wrap", 32'(acc), 32'd3098);
`endif
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        chk("acc_clr", 32'(acc), 32'd0);

        // Saturation of the invalid counter
        for (int i = 0; i < 300; i++) drive(1'b1, 6'(i), 1'b1, 1'b1, 1'b0);
`ifdef ALSU_RESULT_STATS_EN
        chk("inv_sat", 32'(invalid_cnt), 32'd255);
`endif
        drive(1'b1, 6'd3, 1'b1, 1'b1, 1'b0);
`ifdef ALSU_RESULT_STATS_EN
        chk("inv_sat_hold", 32'(invalid_cnt), 32'd255);
`endif
        for (int i = 0; i < 3; i++) drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("final_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
